// File: rtl/clb_config_loader.sv
`default_nettype none
// ============================================================================
// Module   : clb_config_loader
// Purpose  : Serialises a WORD_W-bit valid/ready bitstream LSB-first into a
//            CLB configuration scan chain, shifting exactly CHAIN_LEN bits.
// Revision : 1.0 - initial release
// ============================================================================
module clb_config_loader #(
  parameter int CHAIN_LEN = 1008,
  parameter int WORD_W    = 32,
  parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic              config_clk,
  input  logic              sys_reset_n,
  input  logic              start,
  input  logic              abort,
  input  logic [WORD_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic              cfg_bit,
  output logic              cfg_en,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  bits_done
);

  // Bit-select index into the held word.
  localparam int IDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WORD_W - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CHAIN_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_SHIFT = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]        state_q,     state_d;
  logic [WORD_W-1:0] word_q,      word_d;
  logic [IDX_W-1:0]  bit_idx_q,   bit_idx_d;
  logic [CNT_W-1:0]  bits_done_q, bits_done_d;
  logic              cfg_bit_q,   cfg_bit_d;
  logic              cfg_en_q,    cfg_en_d;

  logic              word_last;
  logic              final_bit;
  logic              accept;

  // Word-exhausted / final-bit decode and the combinational ready handshake.
  always_comb begin
    final_bit = (bits_done_q == CNT_LAST);
    word_last = (bit_idx_q == IDX_LAST) || final_bit;
    s_ready   = 1'b0;
    if (!abort) begin
      case (state_q)
        S_LOAD:  s_ready = 1'b1;
        // Prefetch only when this word ends and more chain bits remain,
        // so no word beyond ceil(CHAIN_LEN/WORD_W) is ever requested.
        S_SHIFT: s_ready = word_last && !final_bit;
        default: s_ready = 1'b0;
      endcase
    end
    accept = s_valid && s_ready;
  end

  // Next-state logic for the load sequencer and the serial output stage.
  always_comb begin
    state_d     = state_q;
    word_d      = word_q;
    bit_idx_d   = bit_idx_q;
    bits_done_d = bits_done_q;
    cfg_bit_d   = cfg_bit_q;
    cfg_en_d    = 1'b0;

    if (abort) begin
      // Partial count stays visible; chain contents are abandoned.
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_d     = S_LOAD;
            bits_done_d = '0;
          end
        end

        S_LOAD: begin
          if (accept) begin
            word_d    = s_data;
            bit_idx_d = '0;
            state_d   = S_SHIFT;
          end
        end

        S_SHIFT: begin
          cfg_bit_d   = word_q[bit_idx_q];
          cfg_en_d    = 1'b1;
          bit_idx_d   = bit_idx_q + IDX_ONE;
          bits_done_d = bits_done_q + CNT_ONE;
          if (final_bit) begin
            state_d = S_DONE;
          end else if (word_last) begin
            if (accept) begin
              word_d    = s_data;
              bit_idx_d = '0;
            end else begin
              state_d = S_LOAD;
            end
          end
        end

        default: state_d = S_IDLE;
      endcase
    end
  end

  // State and output registers; async assert, synchronous release.
  always_ff @(posedge config_clk or negedge sys_reset_n) begin
    if (!sys_reset_n) begin
      state_q     <= S_IDLE;
      word_q      <= '0;
      bit_idx_q   <= '0;
      bits_done_q <= '0;
      cfg_bit_q   <= 1'b0;
      cfg_en_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      word_q      <= word_d;
      bit_idx_q   <= bit_idx_d;
      bits_done_q <= bits_done_d;
      cfg_bit_q   <= cfg_bit_d;
      cfg_en_q    <= cfg_en_d;
    end
  end

  assign cfg_bit   = cfg_bit_q;
  assign cfg_en    = cfg_en_q;
  assign bits_done = bits_done_q;
  assign busy      = (state_q == S_LOAD) || (state_q == S_SHIFT);
  assign done      = (state_q == S_DONE);

`ifndef SYNTHESIS
  // A chain shift can only follow a cycle spent in SHIFT.
  property p_en_from_shift;
    @(posedge config_clk) disable iff (!sys_reset_n)
      cfg_en |-> ($past(state_q) == S_SHIFT);
  endproperty
  a_en_from_shift: assert property (p_en_from_shift);

  // The bit counter never runs past the chain length.
  property p_count_bound;
    @(posedge config_clk) disable iff (!sys_reset_n)
      bits_done <= CNT_W'(CHAIN_LEN);
  endproperty
  a_count_bound: assert property (p_count_bound);

  // Ready is only offered while a load is in progress.
  property p_ready_busy;
    @(posedge config_clk) disable iff (!sys_reset_n)
      s_ready |-> busy;
  endproperty
  a_ready_busy: assert property (p_ready_busy);
`endif

endmodule
`default_nettype wire

// File: tb/tb_clb_config_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_clb_config_loader
// Purpose  : Directed self-checking bench for clb_config_loader (8-bit,
//            20-bit and full 1008-bit chain instances).
// Revision : 1.0 - initial release
// ============================================================================
module tb_clb_config_loader;

  logic config_clk = 1'b0;
  logic sys_reset_n;
  always #5 config_clk = ~config_clk;

  int n_checks = 0;
  int n_errors = 0;
  logic clr;

  // ---------------- 20-bit chain, 8-bit words ----------------
  logic       start, abort, s_valid, s_ready, cfg_bit, cfg_en, busy, done;
  logic [7:0] s_data;
  logic [4:0] bits_done;
  logic [7:0] src_words [0:3];
  int         src_idx, hs_cnt, nbits, gap_cnt;
  logic [19:0] cap;

  assign s_data = (src_idx < 4) ? src_words[src_idx] : 8'h00;

  clb_config_loader #(.CHAIN_LEN(20), .WORD_W(8)) u_dut (
    .config_clk(config_clk), .sys_reset_n(sys_reset_n), .start(start), .abort(abort),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready), .cfg_bit(cfg_bit),
    .cfg_en(cfg_en), .busy(busy), .done(done), .bits_done(bits_done));

  // Chain-side capture and source handshake tracking for the 20-bit instance.
  always @(posedge config_clk) begin
    if (clr) begin
      src_idx <= 0; hs_cnt <= 0; nbits <= 0; gap_cnt <= 0; cap <= '0;
    end else if (sys_reset_n) begin
      if (s_valid && s_ready) begin
        src_idx <= src_idx + 1;
        hs_cnt  <= hs_cnt + 1;
      end
      if (cfg_en) begin
        if (nbits < 20) cap[nbits] <= cfg_bit;
        nbits <= nbits + 1;
      end else if (busy && nbits > 0) begin
        gap_cnt <= gap_cnt + 1;
      end
    end
  end

  // ---------------- 8-bit chain, single word 0xA5 ----------------
  logic       start8, s_ready8, cfg_bit8, cfg_en8, busy8, done8;
  logic       abort_off = 1'b0;
  logic       valid_on  = 1'b1;
  logic [7:0] s_data8   = 8'hA5;
  logic [3:0] bits_done8;
  int         hs8, nbits8, gap8;
  logic [7:0] cap8;

  clb_config_loader #(.CHAIN_LEN(8), .WORD_W(8)) u_dut8 (
    .config_clk(config_clk), .sys_reset_n(sys_reset_n), .start(start8), .abort(abort_off),
    .s_data(s_data8), .s_valid(valid_on), .s_ready(s_ready8), .cfg_bit(cfg_bit8),
    .cfg_en(cfg_en8), .busy(busy8), .done(done8), .bits_done(bits_done8));

  // Capture for the 8-bit instance.
  always @(posedge config_clk) begin
    if (clr) begin
      hs8 <= 0; nbits8 <= 0; gap8 <= 0; cap8 <= '0;
    end else if (sys_reset_n) begin
      if (s_ready8) hs8 <= hs8 + 1;
      if (cfg_en8) begin
        if (nbits8 < 8) cap8[nbits8] <= cfg_bit8;
        nbits8 <= nbits8 + 1;
      end else if (busy8 && nbits8 > 0) begin
        gap8 <= gap8 + 1;
      end
    end
  end

  // ---------------- full 3-BLE chain, 32-bit words ----------------
  logic        start_l, s_ready_l, cfg_bit_l, cfg_en_l, busy_l, done_l;
  logic [31:0] s_data_l;
  logic [9:0]  bits_done_l;
  int          idx_l, hs_l, nbits_l;
  logic [1007:0] chain_l;

  assign s_data_l = 32'h9E3779B9 * 32'(idx_l + 1);

  clb_config_loader u_dut_l (
    .config_clk(config_clk), .sys_reset_n(sys_reset_n), .start(start_l), .abort(abort_off),
    .s_data(s_data_l), .s_valid(valid_on), .s_ready(s_ready_l), .cfg_bit(cfg_bit_l),
    .cfg_en(cfg_en_l), .busy(busy_l), .done(done_l), .bits_done(bits_done_l));

  // Behavioural scan chain; chain_l[1007] is the config_out end.
  always @(posedge config_clk) begin
    if (clr) begin
      idx_l <= 0; hs_l <= 0; nbits_l <= 0; chain_l <= '0;
    end else if (sys_reset_n) begin
      if (s_ready_l) begin
        idx_l <= idx_l + 1;
        hs_l  <= hs_l + 1;
      end
      if (cfg_en_l) begin
        chain_l <= {chain_l[1006:0], cfg_bit_l};
        nbits_l <= nbits_l + 1;
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_stats();
    @(negedge config_clk); clr = 1'b1;
    @(negedge config_clk); clr = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge config_clk); start = 1'b1;
    @(negedge config_clk); start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!done && n < 400) begin @(negedge config_clk); n++; end
    check(tag, 32'(done), 32'd1);
    @(negedge config_clk);
  endtask

  task automatic wait_bits(input string tag, input int val);
    int n = 0;
    while (32'(bits_done) != val && n < 400) begin @(negedge config_clk); n++; end
    check(tag, 32'(bits_done), val);
  endtask

  task automatic check_full20(input string tag);
    check({tag, "_bits"},  32'(cap), 32'h000F00FF);
    check({tag, "_nbits"}, nbits, 32'd20);
    check({tag, "_hs"},    hs_cnt, 32'd3);
    check({tag, "_cnt"},   32'(bits_done), 32'd20);
  endtask

  // Hard stop so the bench can never hang.
  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int n, k, mis;
    logic [31:0] w;
    sys_reset_n = 1'b0;
    start = 1'b0; abort = 1'b0; s_valid = 1'b1; clr = 1'b0;
    start8 = 1'b0; start_l = 1'b0;
    src_words[0] = 8'hFF; src_words[1] = 8'h00; src_words[2] = 8'h0F; src_words[3] = 8'h00;
    repeat (3) @(negedge config_clk);

    // Reset state
    check("rst_sready", 32'(s_ready), 0);
    check("rst_cfg_en", 32'(cfg_en), 0);
    check("rst_cfg_bit", 32'(cfg_bit), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_bits_done", 32'(bits_done), 0);
    sys_reset_n = 1'b1;
    clear_stats();

    // Test 1: single 8-bit word 0xA5 into an 8-bit chain
    @(negedge config_clk); start8 = 1'b1;
    @(negedge config_clk); start8 = 1'b0;
    n = 0;
    while (!done8 && n < 100) begin @(negedge config_clk); n++; end
    check("t1_done", 32'(done8), 1);
    @(negedge config_clk);
    check("t1_bits", 32'(cap8), 32'h000000A5);
    check("t1_nbits", nbits8, 8);
    check("t1_gap", gap8, 0);
    check("t1_hs", hs8, 1);
    check("t1_cnt", 32'(bits_done8), 8);
    check("t1_en_off", 32'(cfg_en8), 0);
    check("t1_busy", 32'(busy8), 0);

    // Test 2: three words, no stalls
    clear_stats();
    pulse_start();
    check("t2_busy", 32'(busy), 1);
    wait_done("t2_done");
    check_full20("t2");
    check("t2_last4", 32'(cap[19:16]), 32'hF);
    check("t2_gap", gap_cnt, 0);
    check("t2_en_off", 32'(cfg_en), 0);

    // Test 3: source withholds word 2 across the prefetch and 5 LOAD cycles
    clear_stats();
    pulse_start();
    n = 0;
    while (hs_cnt < 2 && n < 100) begin @(negedge config_clk); n++; end
    s_valid = 1'b0;
    n = 0; k = 0;
    while (k < 7 && n < 100) begin
      @(negedge config_clk); n++;
      if (s_ready) k++;
    end
    s_valid = 1'b1;
    wait_done("t3_done");
    check_full20("t3");
    check("t3_gap", gap_cnt, 6);

    // Test 4: abort after 10 bits, then a clean reload
    clear_stats();
    pulse_start();
    wait_bits("t4_reach10", 10);
    abort = 1'b1;
    @(negedge config_clk); abort = 1'b0;
    check("t4_busy", 32'(busy), 0);
    check("t4_done", 32'(done), 0);
    check("t4_cfg_en", 32'(cfg_en), 0);
    check("t4_cnt", 32'(bits_done), 10);
    check("t4_nbits", nbits, 10);
    clear_stats();
    pulse_start();
    wait_done("t4_reload_done");
    check_full20("t4_reload");

    // Abort while LOAD offers ready: ready drops at once, no handshake
    clear_stats();
    pulse_start();
    check("t4_load_sready", 32'(s_ready), 1);
    abort = 1'b1;
    #1;
    check("t4_abort_sready", 32'(s_ready), 0);
    @(negedge config_clk); abort = 1'b0;
    check("t4_abort_hs", hs_cnt, 0);
    check("t4_abort_busy", 32'(busy), 0);

    // Test 5: start during SHIFT is ignored; start in DONE restarts
    clear_stats();
    pulse_start();
    wait_bits("t5_reach5", 5);
    pulse_start();
    wait_done("t5_done");
    check_full20("t5");
    clear_stats();
    check("t5_done_held", 32'(done), 1);
    pulse_start();
    check("t5_restart_done", 32'(done), 0);
    check("t5_restart_busy", 32'(busy), 1);
    check("t5_restart_cnt", 32'(bits_done), 0);
    wait_done("t5_restart_fin");
    check_full20("t5_restart");

    // End-to-end: full 1008-bit chain read back through the config_out end
    clear_stats();
    @(negedge config_clk); start_l = 1'b1;
    @(negedge config_clk); start_l = 1'b0;
    n = 0;
    while (!done_l && n < 2000) begin @(negedge config_clk); n++; end
    check("e2e_done", 32'(done_l), 1);
    @(negedge config_clk);
    check("e2e_hs", hs_l, 32);
    check("e2e_nbits", nbits_l, 1008);
    check("e2e_cnt", 32'(bits_done_l), 1008);
    mis = 0;
    for (int i = 0; i < 1008; i++) begin
      w = 32'h9E3779B9 * 32'(i / 32 + 1);
      if (chain_l[1007 - i] !== w[i % 32]) mis++;
    end
    check("e2e_chain_mismatches", mis, 0);

    // Test 6: asynchronous reset in the middle of SHIFT
    clear_stats();
    pulse_start();
    wait_bits("t6_reach7", 7);
    #2 sys_reset_n = 1'b0;
    #1;
    check("t6_cfg_en", 32'(cfg_en), 0);
    check("t6_cfg_bit", 32'(cfg_bit), 0);
    check("t6_busy", 32'(busy), 0);
    check("t6_done", 32'(done), 0);
    check("t6_sready", 32'(s_ready), 0);
    check("t6_cnt", 32'(bits_done), 0);
    @(negedge config_clk); sys_reset_n = 1'b1;
    @(negedge config_clk);
    check("t6_post_done", 32'(done), 0);
    clear_stats();
    pulse_start();
    wait_done("t6_reload_done");
    check_full20("t6_reload");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
